latch_bank_arbiter: RTL and testbench

//   Shares one bank of NLAT transparent D latches (d/e/reset style cells) between NREQ requesters.

---
 rtl/latch_bank_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_latch_bank_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin sharing of one transparent-latch bank, one setup/enable/hold write at a time.
// Optional bank-clear sequence is compiled in when LATCH_ARB_CLEAR_EN is defined.
module latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int NLAT      = 8,
  parameter int AW        = 3,
  parameter int DW        = 1,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                reset,
`ifdef LATCH_ARB_CLEAR_EN
  input  logic                clr_req,
  output logic [NLAT-1:0]     latch_rst,
`endif
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                err,
  output logic                busy,
  output logic [DW-1:0]       latch_d,
  output logic [NLAT-1:0]     latch_e
);

  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (SETUP_CYC > EN_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [AW:0]     NLAT_A  = (AW+1)'(NLAT);
  localparam logic [NLAT-1:0] ONE_LAT = {{(NLAT-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] ONE_REQ = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
`ifdef LATCH_ARB_CLEAR_EN
    , ST_CLEAR = 3'd5
`endif
  } state_t;

  state_t          state_r, state_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic [SW-1:0]   sel_r, sel_nx_s, ptr_r, ptr_nx_s, pick_s;
  logic [AW-1:0]   addr_r, addr_nx_s;
  logic [DW-1:0]   data_r, data_nx_s;
  logic [NREQ*AW-1:0] addr_sh_s;
  logic [NREQ*DW-1:0] data_sh_s;
  logic            addr_ok_s;
  logic            busy_nx_s, err_nx_s;
  logic [NREQ-1:0] gnt_nx_s;
  logic [DW-1:0]   latch_d_nx_s;
  logic [NLAT-1:0] latch_e_nx_s;
`ifdef LATCH_ARB_CLEAR_EN
  logic [NLAT-1:0] latch_rst_nx_s;
`endif

  // First requesting index at or after p, wrapping; smallest distance wins.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [SW-1:0] p);
    logic [SW-1:0]   pick;
    logic [NREQ-1:0] sh;
    int              idx;
    pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sh = r >> idx;
      if (sh[0]) pick = SW'(idx);
    end
    return pick;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign addr_sh_s = req_addr >> (int'(pick_s) * AW);
  assign data_sh_s = req_data >> (int'(pick_s) * DW);

  // Next-state, phase counter and capture logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    sel_nx_s   = sel_r;
    addr_nx_s  = addr_r;
    data_nx_s  = data_r;
    ptr_nx_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = {CW{1'b0}};
`ifdef LATCH_ARB_CLEAR_EN
        if (clr_req) begin
          state_nx_s = ST_CLEAR;
        end else
`endif
        if (|req) begin
          state_nx_s = ST_SETUP;
          sel_nx_s   = pick_s;
          addr_nx_s  = addr_sh_s[AW-1:0];
          data_nx_s  = data_sh_s[DW-1:0];
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CW'(SETUP_CYC - 1)) begin
          state_nx_s = ST_ENABLE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_ENABLE: begin
        if (cnt_r == CW'(EN_CYC - 1)) begin
          state_nx_s = ST_HOLD;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_r == CW'(HOLD_CYC - 1)) begin
          state_nx_s = ST_DONE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        ptr_nx_s   = (sel_r == SW'(NREQ - 1)) ? {SW{1'b0}} : sel_r + SW'(1);
      end
`ifdef LATCH_ARB_CLEAR_EN
      ST_CLEAR: begin
        if (cnt_r == CW'(EN_CYC - 1)) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = {CW{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
`endif
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output values decoded from the upcoming state so every output comes straight from a flop.
  always_comb begin
    addr_ok_s    = ({1'b0, addr_nx_s} < NLAT_A);
    busy_nx_s    = (state_nx_s != ST_IDLE);
    latch_d_nx_s = {DW{1'b0}};
    latch_e_nx_s = {NLAT{1'b0}};
    gnt_nx_s     = {NREQ{1'b0}};
    err_nx_s     = 1'b0;
`ifdef LATCH_ARB_CLEAR_EN
    latch_rst_nx_s = {NLAT{1'b0}};
`endif
    case (state_nx_s)
      ST_SETUP, ST_HOLD: begin
        latch_d_nx_s = data_nx_s;
      end
      ST_ENABLE: begin
        latch_d_nx_s = data_nx_s;
        latch_e_nx_s = addr_ok_s ? (ONE_LAT << addr_nx_s) : {NLAT{1'b0}};
      end
      ST_DONE: begin
        latch_d_nx_s = data_nx_s;
        gnt_nx_s     = ONE_REQ << sel_nx_s;
        err_nx_s     = ~addr_ok_s;
      end
`ifdef LATCH_ARB_CLEAR_EN
      ST_CLEAR: begin
        latch_rst_nx_s = {NLAT{1'b1}};
      end
`endif
      default: begin
        latch_d_nx_s = {DW{1'b0}};
      end
    endcase
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      sel_r     <= {SW{1'b0}};
      ptr_r     <= {SW{1'b0}};
      addr_r    <= {AW{1'b0}};
      data_r    <= {DW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      err       <= 1'b0;
      busy      <= 1'b0;
      latch_d   <= {DW{1'b0}};
      latch_e   <= {NLAT{1'b0}};
`ifdef LATCH_ARB_CLEAR_EN
      latch_rst <= {NLAT{1'b0}};
`endif
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      sel_r     <= sel_nx_s;
      ptr_r     <= ptr_nx_s;
      addr_r    <= addr_nx_s;
      data_r    <= data_nx_s;
      gnt       <= gnt_nx_s;
      err       <= err_nx_s;
      busy      <= busy_nx_s;
      latch_d   <= latch_d_nx_s;
      latch_e   <= latch_e_nx_s;
`ifdef LATCH_ARB_CLEAR_EN
      latch_rst <= latch_rst_nx_s;
`endif
    end
  end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed self-checking bench for latch_bank_arbiter (AW widened to 4 so out-of-range addresses are reachable).
module tb_latch_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NLAT = 8;
  localparam int AW   = 4;
  localparam int DW   = 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                err;
  logic                busy;
  logic [DW-1:0]       latch_d;
  logic [NLAT-1:0]     latch_e;
`ifdef LATCH_ARB_CLEAR_EN
  logic                clr_req;
  logic [NLAT-1:0]     latch_rst;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  latch_bank_arbiter #(
    .NREQ(NREQ), .NLAT(NLAT), .AW(AW), .DW(DW),
    .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef LATCH_ARB_CLEAR_EN
    .clr_req  (clr_req),
    .latch_rst(latch_rst),
`endif
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .err      (err),
    .busy     (busy),
    .latch_d  (latch_d),
    .latch_e  (latch_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int          addr3 [4];
    logic [3:0]  data3;
    int          p;
    int          r;
    addr3 = '{1, 2, 3, 6};
    data3 = 4'b0101;

    // reset held with all requests high
    reset    = 1'b1;
    req      = 4'b1111;
    req_addr = 16'h0000;
    req_data = 4'b0000;
`ifdef LATCH_ARB_CLEAR_EN
    clr_req  = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_e", 32'(latch_e), 32'h0);
      chk("rst_d", 32'(latch_d), 32'h0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // single write: requester 0, addr 5, data 1
    req              = 4'b0001;
    req_addr[0 +: 4] = 4'd5;
    req_data[0]      = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("w1_e", 32'(latch_e), (k == 2 || k == 3) ? 32'h20 : 32'h0);
      chk("w1_gnt", 32'(gnt), (k == 5) ? 32'h1 : 32'h0);
      chk("w1_busy", 32'(busy), (k <= 5) ? 32'h1 : 32'h0);
      if (k <= 4 || k == 6) chk("w1_d", 32'(latch_d), (k <= 4) ? 32'h1 : 32'h0);
      if (k == 5) begin
        chk("w1_err", 32'(err), 32'h0);
        req = 4'b0000;
      end
    end

    // round robin with all requesters held, from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[i*4 +: 4] = 4'(addr3[i]);
    req_data = data3;
    req      = 4'b1111;
    for (int k = 1; k <= 30; k++) begin
      tick();
      p = (k - 1) % 6;
      r = ((k - 1) / 6) % 4;
      chk("rr_gnt", 32'(gnt), (p == 4) ? (32'h1 << r) : 32'h0);
      chk("rr_e", 32'(latch_e), (p == 1 || p == 2) ? (32'h1 << addr3[r]) : 32'h0);
      chk("rr_busy", 32'(busy), (p != 5) ? 32'h1 : 32'h0);
      if (p <= 3) chk("rr_d", 32'(latch_d), 32'(data3[r]));
      if (p == 5) chk("rr_d_idle", 32'(latch_d), 32'h0);
      if (p == 4) chk("rr_err", 32'(err), 32'h0);
      if (k == 29) req = 4'b0000;
    end

    // requester 2: in-range address, then out-of-range with a late address change
    req               = 4'b0100;
    req_addr[8 +: 4]  = 4'd7;
    req_data[2]       = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("oor_e", 32'(latch_e), (k == 2 || k == 3) ? 32'h80 : 32'h0);
      chk("oor_gnt", 32'(gnt), (k == 5 || k == 11) ? 32'h4 : 32'h0);
      chk("oor_err", 32'(err), (k == 11) ? 32'h1 : 32'h0);
      chk("oor_busy", 32'(busy), (k == 6 || k == 12) ? 32'h0 : 32'h1);
      if (k == 5) req_addr[8 +: 4] = 4'd9;
      if (k == 7) req_addr[8 +: 4] = 4'd7;
      if (k == 11) req = 4'b0000;
    end

    // reset during ENABLE aborts the write and clears the pointer
    req               = 4'b1000;
    req_addr[12 +: 4] = 4'd4;
    req_data[3]       = 1'b1;
    req_addr[0 +: 4]  = 4'd5;
    tick();
    chk("ab_d", 32'(latch_d), 32'h1);
    tick();
    chk("ab_e_pre", 32'(latch_e), 32'h10);
    reset = 1'b1;
    tick();
    chk("ab_e", 32'(latch_e), 32'h0);
    chk("ab_d0", 32'(latch_d), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_gnt", 32'(gnt), 32'h0);
    reset = 1'b0;
    req   = 4'b1111;
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("ab_rr_gnt", 32'(gnt), (k == 8) ? 32'h1 : 32'h0);
      if (k == 5) chk("ab_rr_e", 32'(latch_e), 32'h20);
      if (k == 8) req = 4'b0000;
    end

`ifdef LATCH_ARB_CLEAR_EN
    // clear takes priority over a pending write
    clr_req          = 1'b1;
    req              = 4'b0010;
    req_addr[4 +: 4] = 4'd2;
    req_data[1]      = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("clr_rst", 32'(latch_rst), (k == 1 || k == 2) ? 32'hFF : 32'h0);
      chk("clr_busy", 32'(busy), (k == 3 || k == 9) ? 32'h0 : 32'h1);
      chk("clr_gnt", 32'(gnt), (k == 8) ? 32'h2 : 32'h0);
      chk("clr_e", 32'(latch_e), (k == 5 || k == 6) ? 32'h04 : 32'h0);
      if (k == 1) clr_req = 1'b0;
      if (k == 8) req = 4'b0000;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
